// File: rtl/unified_mem_arbiter.sv
// Purpose: shares one single-ported memory between instruction fetch and data access, one access in flight.
// Latency: request seen in IDLE at t -> mem_req_o at t+1 -> mem_ack_i at t+1+L -> port ack pulse at t+2+L.
// Backpressure: mem_req_o held until mem_ack_i; losing/waiting port sees stall_*_o until its ack pulse.
module unified_mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [1:0]  d_store_type_i,
  input  logic [2:0]  d_load_type_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [1:0]  mem_store_type_o,
  output logic [2:0]  mem_load_type_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        stall_if_o,
  output logic        stall_mem_o,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX   = 4'(MAX_DATA_STREAK);
  // Fetches are always full words, read zero-extended.
  localparam logic [1:0] STORE_WORD   = 2'b10;
  localparam logic [2:0] LOAD_WORD_U  = 3'b110;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  streak;
  logic        take_if;
  logic        take_d;
  logic        owner_d;   // 1: current access belongs to the data port
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_store_type;
  logic [2:0]  lat_load_type;
  logic [31:0] if_rdata;
  logic [31:0] d_rdata;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Arbitration, next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    take_if   = 1'b0;
    take_d    = 1'b0;
    mem_req_o = 1'b0;
    if_ack_o  = 1'b0;
    d_ack_o   = 1'b0;
    grant_o   = 2'b00;
    case (state)
      IDLE: begin
        // Data wins ties unless fetch has waited through a full streak.
        if (d_req_i && !(if_req_i && (streak == STREAK_MAX))) begin
          take_d    = 1'b1;
          state_nxt = BUSY_D;
        end else if (if_req_i) begin
          take_if   = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF: begin
        mem_req_o = 1'b1;
        grant_o   = 2'b01;
        if (mem_ack_i) state_nxt = RESP;
      end
      BUSY_D: begin
        mem_req_o = 1'b1;
        grant_o   = 2'b10;
        if (mem_ack_i) state_nxt = RESP;
      end
      RESP: begin
        if_ack_o  = ~owner_d;
        d_ack_o   = owner_d;
        grant_o   = owner_d ? 2'b10 : 2'b01;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Count consecutive data grants taken while fetch is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= 4'd0;
    end else if (take_if) begin
      streak <= 4'd0;
    end else if (take_d) begin
      if (!if_req_i)                 streak <= 4'd0;
      else if (streak >= STREAK_MAX) streak <= STREAK_MAX;
      else                           streak <= streak + 4'd1;
    end
  end

  // Latch the winning request so the requester's fields may change after its ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_d        <= 1'b0;
      lat_we         <= 1'b0;
      lat_addr       <= 32'd0;
      lat_wdata      <= 32'd0;
      lat_store_type <= 2'd0;
      lat_load_type  <= 3'd0;
    end else if (take_d) begin
      owner_d        <= 1'b1;
      lat_we         <= d_we_i;
      lat_addr       <= d_addr_i;
      lat_wdata      <= d_wdata_i;
      lat_store_type <= d_store_type_i;
      lat_load_type  <= d_load_type_i;
    end else if (take_if) begin
      owner_d        <= 1'b0;
      lat_we         <= 1'b0;
      lat_addr       <= if_addr_i;
      lat_wdata      <= 32'd0;
      lat_store_type <= STORE_WORD;
      lat_load_type  <= LOAD_WORD_U;
    end
  end

  // Capture returned data per port; each port keeps its last value between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
    end else if (mem_ack_i) begin
      if (state == BUSY_IF) if_rdata <= mem_rdata_i;
      if (state == BUSY_D)  d_rdata  <= mem_rdata_i;
    end
  end

  assign mem_we_o         = mem_req_o & lat_we;
  assign mem_addr_o       = lat_addr;
  assign mem_wdata_o      = lat_wdata;
  assign mem_store_type_o = lat_store_type;
  assign mem_load_type_o  = lat_load_type;
  assign if_rdata_o       = if_rdata;
  assign d_rdata_o        = d_rdata;
  assign stall_if_o       = if_req_i & ~if_ack_o;
  assign stall_mem_o      = d_req_i & ~d_ack_o;

endmodule
